// File: rtl/mod_exp_sequencer.sv
// Issuing side of the modular multiplier: left-to-right square-and-multiply over
// every exponent bit, one multiply in flight, with a response watchdog.
module mod_exp_sequencer #(
    parameter int EXP_BITS = 256,
    parameter int TIMEOUT  = 64,
    parameter int CNT_W    = 9
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    input  logic [255:0]        base,
    input  logic [EXP_BITS-1:0] exponent,
    output logic                busy,
    output logic                done,
    output logic                error,
    output logic [255:0]        result,
    output logic                mul_in_valid,
    output logic [255:0]        mul_x,
    output logic [255:0]        mul_y,
    input  logic [255:0]        mul_q,
    input  logic                mul_out_valid
);

    // state    | meaning
    // IDLE     | waiting for start
    // SQ_ISSUE | issue acc*acc
    // SQ_WAIT  | wait for square result
    // MU_ISSUE | issue acc*base
    // MU_WAIT  | wait for multiply result
    // FINISH   | publish result, pulse done
    // ERR      | watchdog expired, flag error, pulse done
    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] SQ_ISSUE = 3'd1;
    localparam logic [2:0] SQ_WAIT  = 3'd2;
    localparam logic [2:0] MU_ISSUE = 3'd3;
    localparam logic [2:0] MU_WAIT  = 3'd4;
    localparam logic [2:0] FINISH   = 3'd5;
    localparam logic [2:0] ERR      = 3'd6;

    localparam logic [CNT_W-1:0]    IDX_LAST = CNT_W'(EXP_BITS - 1);
    localparam logic [CNT_W-1:0]    IDX_ONE  = CNT_W'(1);
    localparam logic [6:0]          WDOG_MAX = 7'(TIMEOUT);
    localparam logic [EXP_BITS-1:0] EXP_ONE  = EXP_BITS'(1);

    logic [2:0]          state_q, state_d;
    logic [255:0]        acc_q, acc_d;
    logic [255:0]        base_q, base_d;
    logic [EXP_BITS-1:0] exp_q, exp_d;
    logic [CNT_W-1:0]    idx_q, idx_d;
    logic [6:0]          wdog_q, wdog_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                error_q, error_d;
    logic [255:0]        result_q, result_d;
    logic [255:0]        mul_x_q, mul_x_d;
    logic [255:0]        mul_y_q, mul_y_d;
    logic                waiting;
    logic                cur_bit;

    assign waiting = (state_q == SQ_WAIT) || (state_q == MU_WAIT);
    assign cur_bit = |(exp_q & (EXP_ONE << idx_q));

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        base_d   = base_q;
        exp_d    = exp_q;
        idx_d    = idx_q;
        wdog_d   = wdog_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        error_d  = error_q;
        result_d = result_q;
        mul_x_d  = mul_x_q;
        mul_y_d  = mul_y_q;

        // A response outside a wait state is a protocol fault, except a stale one after an abort.
        if (mul_out_valid && !waiting && !(state_q == IDLE && !busy_q)) begin
            error_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    base_d  = base;
                    exp_d   = exponent;
                    acc_d   = 256'd1;
                    idx_d   = IDX_LAST;
                    error_d = 1'b0;
                    busy_d  = 1'b1;
                    state_d = (exponent == '0) ? FINISH : SQ_ISSUE;
                end
            end
            SQ_ISSUE: begin
                mul_x_d = acc_q;
                mul_y_d = acc_q;
                wdog_d  = '0;
                state_d = SQ_WAIT;
            end
            SQ_WAIT: begin
                if (mul_out_valid) begin
                    acc_d = mul_q;
                    if (cur_bit) begin
                        state_d = MU_ISSUE;
                    end else if (idx_q == '0) begin
                        state_d = FINISH;
                    end else begin
                        idx_d   = idx_q - IDX_ONE;
                        state_d = SQ_ISSUE;
                    end
                end else if (wdog_q == WDOG_MAX) begin
                    state_d = ERR;
                end else begin
                    wdog_d = wdog_q + 7'd1;
                end
            end
            MU_ISSUE: begin
                mul_x_d = acc_q;
                mul_y_d = base_q;
                wdog_d  = '0;
                state_d = MU_WAIT;
            end
            MU_WAIT: begin
                if (mul_out_valid) begin
                    acc_d = mul_q;
                    if (idx_q == '0) begin
                        state_d = FINISH;
                    end else begin
                        idx_d   = idx_q - IDX_ONE;
                        state_d = SQ_ISSUE;
                    end
                end else if (wdog_q == WDOG_MAX) begin
                    state_d = ERR;
                end else begin
                    wdog_d = wdog_q + 7'd1;
                end
            end
            FINISH: begin
                result_d = acc_q;
                done_d   = 1'b1;
                busy_d   = 1'b0;
                state_d  = IDLE;
            end
            ERR: begin
                error_d = 1'b1;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            base_q   <= '0;
            exp_q    <= '0;
            idx_q    <= '0;
            wdog_q   <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
            result_q <= '0;
            mul_x_q  <= '0;
            mul_y_q  <= '0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            base_q   <= base_d;
            exp_q    <= exp_d;
            idx_q    <= idx_d;
            wdog_q   <= wdog_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            error_q  <= error_d;
            result_q <= result_d;
            mul_x_q  <= mul_x_d;
            mul_y_q  <= mul_y_d;
        end
    end

    // Operands go out in the issue cycle itself and are held afterwards.
    assign mul_in_valid = (state_q == SQ_ISSUE) || (state_q == MU_ISSUE);
    assign mul_x        = mul_x_d;
    assign mul_y        = mul_y_d;
    assign busy         = busy_q;
    assign done         = done_q;
    assign error        = error_q;
    assign result       = result_q;

endmodule

// File: tb/tb_mod_exp_sequencer.sv
// Bench for mod_exp_sequencer: behavioural mod-p multiplier with programmable latency,
// a vector table of exponentiations, and hand-written timeout / reset / busy-start sequences.
module tb_mod_exp_sequencer;

    localparam logic [255:0] P = (256'd1 << 255) - 256'd19;

    logic         clock = 1'b0;
    logic         reset;
    logic         start;
    logic [255:0] base;
    logic [255:0] exponent;
    logic         busy, done, error;
    logic [255:0] result;
    logic         mul_in_valid;
    logic [255:0] mul_x, mul_y;
    logic [255:0] mul_q;
    logic         mul_out_valid;

    logic         model_valid;
    logic         inj_valid;
    logic [255:0] model_q, pend_q;
    int           cnt;
    int           mul_lat;
    logic         mute;
    int           issue_total;
    int           b2b_viol;
    logic         prev_iv;

    int passed = 0;
    int total  = 0;

    always #5 clock = ~clock;

    mod_exp_sequencer dut (
        .clock         (clock),
        .reset         (reset),
        .start         (start),
        .base          (base),
        .exponent      (exponent),
        .busy          (busy),
        .done          (done),
        .error         (error),
        .result        (result),
        .mul_in_valid  (mul_in_valid),
        .mul_x         (mul_x),
        .mul_y         (mul_y),
        .mul_q         (mul_q),
        .mul_out_valid (mul_out_valid)
    );

    assign mul_out_valid = model_valid | inj_valid;
    assign mul_q         = model_q;

    function automatic logic [255:0] modmul(input logic [255:0] a, input logic [255:0] b);
        logic [511:0] prod;
        prod = {256'd0, a} * {256'd0, b};
        return 256'(prod % {256'd0, P});
    endfunction

    // Multiplier model: response mul_lat cycles after the issue cycle.
    always @(posedge clock) begin
        if (reset) begin
            model_valid <= 1'b0;
            model_q     <= '0;
            cnt         <= 0;
        end else begin
            model_valid <= 1'b0;
            if (mul_in_valid) begin
                pend_q <= modmul(mul_x, mul_y);
                if (mul_lat <= 1) begin
                    model_valid <= !mute;
                    model_q     <= modmul(mul_x, mul_y);
                end else begin
                    cnt <= mul_lat - 1;
                end
            end else if (cnt != 0) begin
                cnt <= cnt - 1;
                if (cnt == 1 && !mute) begin
                    model_valid <= 1'b1;
                    model_q     <= pend_q;
                end
            end
        end
    end

    always @(negedge clock) begin
        if (reset) begin
            prev_iv <= 1'b0;
        end else begin
            prev_iv <= mul_in_valid;
            if (mul_in_valid) issue_total <= issue_total + 1;
            if (mul_in_valid && prev_iv) b2b_viol <= b2b_viol + 1;
        end
    end

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] req);
        total++;
        if (act !== req) $display("FAIL %s: got %0h, required %0h", name, act, req);
        else passed++;
    endtask

    // Starts an op, scrambles the input operands after capture, optionally pokes start
    // mid-operation, and returns cycles from the start cycle to done plus issue count.
    task automatic run_op(input logic [255:0] b, input logic [255:0] e, input int poke,
                          input int bound, output int n, output int iss);
        int i0;
        @(negedge clock);
        base     = b;
        exponent = e;
        start    = 1'b1;
        i0       = issue_total;
        @(negedge clock);
        start    = 1'b0;
        base     = {8{32'hdeadbeef}};
        exponent = {8{32'h12345678}};
        n        = 1;
        while (!done && n < bound) begin
            start = (n == poke);
            @(negedge clock);
            n++;
        end
        start = 1'b0;
        iss   = issue_total - i0;
    endtask

    typedef struct {
        logic [255:0] b;
        logic [255:0] e;
        logic [255:0] res;
        int           issues;
        int           lat;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int n, iss, exp_lat;
        logic [255:0] last_res;

        vecs[0] = '{256'd5,   256'd1,  256'd5,              257, 1};
        vecs[1] = '{256'd3,   256'd2,  256'd9,              257, 1};
        vecs[2] = '{256'd2,   256'd3,  256'd8,              258, 2};
        vecs[3] = '{256'd123, 256'd0,  256'd1,              0,   1};
        vecs[4] = '{256'd7,   256'd16, 256'd33232930569601, 257, 3};
        vecs[5] = '{P - 1,    256'd3,  P - 1,               258, 1};
        vecs[6] = '{P - 1,    256'd2,  256'd1,              257, 1};

        reset = 1'b1; start = 1'b0; base = '0; exponent = '0;
        inj_valid = 1'b0; mute = 1'b0; mul_lat = 1;
        issue_total = 0; b2b_viol = 0;
        repeat (3) @(negedge clock);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        chk("rst_result", result, 0);
        chk("rst_in_valid", mul_in_valid, 0);
        chk("rst_mul_x", mul_x, 0);
        chk("rst_mul_y", mul_y, 0);
        reset = 1'b0;

        for (int i = 0; i < 7; i++) begin
            mul_lat = vecs[i].lat;
            exp_lat = 2 + vecs[i].issues * (1 + vecs[i].lat);
            run_op(vecs[i].b, vecs[i].e, 0, exp_lat + 10, n, iss);
            chk($sformatf("v%0d_result", i), result, vecs[i].res);
            chk($sformatf("v%0d_issues", i), 256'(iss), 256'(vecs[i].issues));
            chk($sformatf("v%0d_latency", i), 256'(n), 256'(exp_lat));
            chk($sformatf("v%0d_error", i), error, 0);
            chk($sformatf("v%0d_busy_at_done", i), busy, 0);
            @(negedge clock);
            chk($sformatf("v%0d_done_once", i), done, 0);
        end
        last_res = 256'd1;

        // Start while busy must not recapture: result stays 3^2.
        mul_lat = 1;
        run_op(256'd3, 256'd2, 100, 600, n, iss);
        chk("busy_start_result", result, 256'd9);
        chk("busy_start_issues", 256'(iss), 256'd257);
        chk("busy_start_latency", 256'(n), 256'd516);
        last_res = 256'd9;

        // Silent multiplier: issue in cycle 1, wdog hits 64 in cycle 65, ERR in 66, done in 67+1.
        mute = 1'b1;
        run_op(256'd3, 256'd1, 0, 100, n, iss);
        chk("to_latency", 256'(n), 256'd68);
        chk("to_done", done, 1);
        chk("to_error", error, 1);
        chk("to_busy", busy, 0);
        chk("to_result_kept", result, last_res);
        chk("to_issues", 256'(iss), 256'd1);
        @(negedge clock);
        chk("to_done_once", done, 0);
        chk("to_error_sticky", error, 1);
        repeat (3) @(negedge clock);
        chk("to_idle_no_issue", mul_in_valid, 0);
        mute = 1'b0;

        run_op(256'd2, 256'd3, 0, 600, n, iss);
        chk("after_to_error_cleared", error, 0);
        chk("after_to_result", result, 256'd8);

        // Response arriving on the exact cycle wdog reaches 64 is accepted.
        mul_lat = 65;
        run_op(256'd5, 256'd1, 0, 17000, n, iss);
        chk("edge_lat65_error", error, 0);
        chk("edge_lat65_result", result, 256'd5);
        chk("edge_lat65_latency", 256'(n), 256'd16964);

        // One cycle too slow times out.
        mul_lat = 66;
        run_op(256'd5, 256'd1, 0, 100, n, iss);
        chk("edge_lat66_latency", 256'(n), 256'd68);
        chk("edge_lat66_error", error, 1);
        repeat (4) @(negedge clock);

        // Reset during MU_WAIT: exponent MSB set so the second issue is acc*base in cycle 7.
        mul_lat = 5;
        @(negedge clock);
        base = 256'd2; exponent = 256'd1 << 255; start = 1'b1;
        @(negedge clock);
        start = 1'b0; base = {8{32'hdeadbeef}};
        repeat (6) @(negedge clock);
        chk("mu_issue_valid", mul_in_valid, 1);
        chk("mu_issue_x", mul_x, 256'd1);
        chk("mu_issue_y", mul_y, 256'd2);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_error", error, 0);
        chk("abort_result", result, 0);
        chk("abort_in_valid", mul_in_valid, 0);
        chk("abort_mul_x", mul_x, 0);
        chk("abort_mul_y", mul_y, 0);
        repeat (10) @(negedge clock);
        inj_valid = 1'b1;
        @(negedge clock);
        inj_valid = 1'b0;
        @(negedge clock);
        chk("stale_valid_error", error, 0);
        chk("stale_valid_done", done, 0);
        chk("stale_valid_busy", busy, 0);

        chk("no_back_to_back_issue", 256'(b2b_viol), 256'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/mod_exp_sequencer.md
Name: mod_exp_sequencer

Overview:
- Issuing side of the pipelined 256-bit modular multiplier interface.
- Accepts a base and an exponent, then computes base^exponent mod p by left-to-right square-and-multiply.
- Drives the multiplier's in_valid/X/Y and consumes its Q/out_valid.
- Sits between the host command interface and the multiplier core.
- One multiply is in flight at a time, because each step depends on the previous result.

Parameters:
- EXP_BITS, 256, exponent width; number of bits scanned.
- TIMEOUT, 64, max cycles to wait for mul_out_valid after an issue before flagging error.
- CNT_W, 9, width of the bit index counter; must satisfy 2^CNT_W > EXP_BITS.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- base  in  256  operand; captured on accepted start.
- exponent  in  EXP_BITS  exponent; captured on accepted start.
- busy  out  1  high from the cycle after accepted start until done.
- done  out  1  one-cycle pulse; result valid in the same cycle.
- error  out  1  sticky; cleared on next accepted start or reset.
- result  out  256  final value; held until next accepted start.
- mul_in_valid  out  1  one-cycle issue strobe to the multiplier.
- mul_x  out  256  multiplier X operand.
- mul_y  out  256  multiplier Y operand.
- mul_q  in  256  multiplier result.
- mul_out_valid  in  1  multiplier result strobe.

Behaviour:
- Reset values: busy=0, done=0, error=0, result=0, mul_in_valid=0, mul_x=0, mul_y=0. State returns to IDLE.
- Reset mid-operation aborts silently. A later stale mul_out_valid arriving in IDLE is ignored and does not set error.
- Registers: acc (256), base_r (256), exp_r (EXP_BITS), idx (CNT_W), wdog (7).

States and transitions:
- IDLE:
  - start=1 captures base/exponent, sets acc=1, idx=EXP_BITS-1, clears error and goes to SQ_ISSUE.
  - If exponent==0, goes to FINISH instead, with acc=1.
- SQ_ISSUE: drives mul_in_valid=1 for exactly one cycle with mul_x=mul_y=acc, clears wdog, then goes to SQ_WAIT.
- SQ_WAIT: on mul_out_valid, sets acc<=mul_q.
  - If exp_r[idx]=1, goes to MU_ISSUE.
  - Otherwise, if idx==0 goes to FINISH, else idx--, back to SQ_ISSUE.
- MU_ISSUE: drives mul_in_valid=1 for one cycle with mul_x=acc, mul_y=base_r, then goes to MU_WAIT.
- MU_WAIT: on mul_out_valid, sets acc<=mul_q.
  - If idx==0 goes to FINISH, else idx--, back to SQ_ISSUE.
- FINISH: sets result<=acc, done=1 for one cycle, busy<=0, then goes to IDLE.
- ERR:
  - Entered from SQ_WAIT or MU_WAIT when wdog reaches TIMEOUT.
  - Sets error=1, done=1 for one cycle, result unchanged, then goes to IDLE.

General rules:
- mul_x/mul_y hold their last driven value outside issue cycles; mul_in_valid is never high for two consecutive cycles.
- Leading zero bits are still scanned (squaring 1 yields 1). The cycle count is therefore a function of EXP_BITS and popcount only, giving constant-time behaviour for fixed popcount.
- Total issues = EXP_BITS + popcount(exponent).
- Latency from start to done = 1 + sum over issues of (1 + L), plus 1, where L is the multiplier latency.
- start while busy is ignored, with no effect on state or captured operands.
- mul_out_valid in any state other than SQ_WAIT/MU_WAIT sets error (sticky) and is otherwise ignored; this includes IDLE only while busy is high.
- mul_out_valid arriving in the same cycle wdog hits TIMEOUT counts as a valid response, not a timeout.
- No arithmetic is performed here; all reduction is done by the multiplier.

Test Plan:
- base=5, exponent=1, with the real multiplier -> exactly 257 mul_in_valid pulses, result=5, done pulses once, error=0.
- base=3, exponent=2 -> result=9; base=2, exponent=3 -> result=8. Issue counts are 257 and 258 respectively.
- exponent=0, base=anything -> done 2 cycles after start, result=1, zero mul_in_valid pulses.
- Behavioral multiplier model that never asserts out_valid:
  - Expect error=1 and done one cycle after wdog reaches 64.
  - Expect state IDLE, busy=0.
  - A following start clears error.
- Reset and start interactions:
  - Assert reset during MU_WAIT: all outputs zero next cycle.
  - Inject an out_valid 10 cycles later: error stays 0.
  - start asserted while busy: no second capture, result matches the first operands.
